// File: rtl/vme_pkg.sv
// -----------------------------------------------------------------------------
// vme_pkg
//   Shared types and constants for the VME read-path arbiter and its
//   in-flight burst tracker.
//
//   Contents:
//     ADDR_W / LEN_W / TAG_W / DATA_W  widths of the VME read channels
//     DEF_MAX_OUTSTANDING              default depth of the in-flight FIFO
//     client_id_t                      1-bit client index (0 = input loader,
//                                      1 = weight loader)
//     rd_cmd_t                         read command {addr, len, tag}
//     rd_data_t                        read data beat {data, tag}
//     inflight_t                       in-flight burst record {id, len}
//     arb_state_t                      command grant state (open / held)
// -----------------------------------------------------------------------------
package vme_pkg;

   localparam int ADDR_W              = 32;
   localparam int LEN_W               = 8;   // len = beats - 1
   localparam int TAG_W               = 21;
   localparam int DATA_W              = 64;
   localparam int DEF_MAX_OUTSTANDING = 4;

   typedef logic [0:0] client_id_t;

   localparam client_id_t CLIENT_INP = 1'b0;   // input-tensor loader
   localparam client_id_t CLIENT_WGT = 1'b1;   // weight loader

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
      logic [TAG_W-1:0]  tag;
   } rd_cmd_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [TAG_W-1:0]  tag;
   } rd_data_t;

   // One entry per accepted burst: who asked for it and how many beats
   // (minus one) it will return.
   typedef struct packed {
      client_id_t       id;
      logic [LEN_W-1:0] len;
   } inflight_t;

   // ARB_HELD: a command was presented to memory but not yet taken, so the
   // grant must not move until the handshake completes.
   typedef enum logic {
      ARB_OPEN = 1'b0,
      ARB_HELD = 1'b1
   } arb_state_t;

   function automatic client_id_t otherClient(input client_id_t id);
      return ~id;
   endfunction

endpackage

// File: rtl/inflight_fifo.sv
// -----------------------------------------------------------------------------
// inflight_fifo
//   Synchronous FIFO of in-flight burst records {client id, len}, kept in
//   command-acceptance order so returned beats can be steered to the client
//   that issued them.
//
//   Ports:
//     clock      in   rising-edge clock
//     reset      in   asynchronous active-low reset (empties the FIFO)
//     push       in   write pushEntry (ignored while full)
//     pushEntry  in   record to write
//     pop        in   drop the head record (ignored while empty)
//     full       out  DEPTH records held
//     empty      out  no records held
//     head       out  oldest record, valid whenever !empty
//
//   Pointers carry one extra wrap bit: equal pointers mean empty, equal
//   index bits with differing wrap bits mean full.
// -----------------------------------------------------------------------------
module inflight_fifo
   import vme_pkg::*;
#(
   parameter int DEPTH = DEF_MAX_OUTSTANDING
) (
   input  logic      clock,
   input  logic      reset,
   input  logic      push,
   input  inflight_t pushEntry,
   input  logic      pop,
   output logic      full,
   output logic      empty,
   output inflight_t head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0] wrPtr;
   logic [AW:0] rdPtr;
   logic        doPush;
   logic        doPop;

   // Tiny storage read asynchronously: the head has to steer the very beat
   // that is on the memory port this cycle.
   inflight_t store [DEPTH];

   assign empty  = (wrPtr == rdPtr);
   assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
   assign doPush = push & ~full;
   assign doPop  = pop & ~empty;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + PTR_ONE;
         end
         if (doPop) begin
            rdPtr <= rdPtr + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (doPush) begin
         store[wrPtr[AW-1:0]] <= pushEntry;
      end
   end

   assign head = store[rdPtr[AW-1:0]];

endmodule

// File: rtl/vme_rd_arbiter.sv
// -----------------------------------------------------------------------------
// vme_rd_arbiter
//   Shares one memory-side VME read port between two tensor loaders
//   (client 0 = input loader, client 1 = weight loader).
//
//   Command side: round-robin grant, combinational forward of the granted
//   client's {addr, len, tag}. Once a command is shown to memory without
//   being accepted the grant is frozen until it is taken. Each accepted
//   command records {client, len} in an in-order in-flight FIFO.
//
//   Data side: the FIFO head decides which client sees io_mem_rd_data_*.
//   A beat counter finds the last beat of the head burst and pops it.
//   Beats arriving with nothing in flight are swallowed and flag io_err.
//
//   Ports:
//     clock, reset                      clock / async active-low reset
//     io_client_{0,1}_rd_cmd_*          client command channels (valid/ready)
//     io_client_{0,1}_rd_data_*         client data channels (valid/ready)
//     io_mem_rd_cmd_*                   memory command channel
//     io_mem_rd_data_*                  memory data channel
//     io_busy                           at least one burst in flight
//     io_err                            sticky: stray beat seen
// -----------------------------------------------------------------------------
module vme_rd_arbiter
   import vme_pkg::*;
#(
   parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
   input  logic              clock,
   input  logic              reset,

   input  logic              io_client_0_rd_cmd_valid,
   output logic              io_client_0_rd_cmd_ready,
   input  logic [ADDR_W-1:0] io_client_0_rd_cmd_bits_addr,
   input  logic [LEN_W-1:0]  io_client_0_rd_cmd_bits_len,
   input  logic [TAG_W-1:0]  io_client_0_rd_cmd_bits_tag,
   output logic              io_client_0_rd_data_valid,
   input  logic              io_client_0_rd_data_ready,
   output logic [DATA_W-1:0] io_client_0_rd_data_bits_data,
   output logic [TAG_W-1:0]  io_client_0_rd_data_bits_tag,

   input  logic              io_client_1_rd_cmd_valid,
   output logic              io_client_1_rd_cmd_ready,
   input  logic [ADDR_W-1:0] io_client_1_rd_cmd_bits_addr,
   input  logic [LEN_W-1:0]  io_client_1_rd_cmd_bits_len,
   input  logic [TAG_W-1:0]  io_client_1_rd_cmd_bits_tag,
   output logic              io_client_1_rd_data_valid,
   input  logic              io_client_1_rd_data_ready,
   output logic [DATA_W-1:0] io_client_1_rd_data_bits_data,
   output logic [TAG_W-1:0]  io_client_1_rd_data_bits_tag,

   output logic              io_mem_rd_cmd_valid,
   input  logic              io_mem_rd_cmd_ready,
   output logic [ADDR_W-1:0] io_mem_rd_cmd_bits_addr,
   output logic [LEN_W-1:0]  io_mem_rd_cmd_bits_len,
   output logic [TAG_W-1:0]  io_mem_rd_cmd_bits_tag,
   input  logic              io_mem_rd_data_valid,
   output logic              io_mem_rd_data_ready,
   input  logic [DATA_W-1:0] io_mem_rd_data_bits_data,
   input  logic [TAG_W-1:0]  io_mem_rd_data_bits_tag,

   output logic              io_busy,
   output logic              io_err
);

   localparam logic [LEN_W-1:0] BEAT_ONE = 1;

   // While reset is held low every valid/ready output is forced low, even if
   // the neighbours are still driving their own handshake inputs.
   logic outEn;
   assign outEn = reset;

   // ---------------------------------------------------------------------
   // Client channels gathered into indexable vectors
   // ---------------------------------------------------------------------
   logic [1:0] cmdValidVec;
   logic [1:0] cmdReadyVec;
   logic [1:0] dataValidVec;
   logic [1:0] dataReadyVec;
   rd_cmd_t    cmdVec [2];
   rd_data_t   memBeat;

   assign cmdValidVec  = {io_client_1_rd_cmd_valid, io_client_0_rd_cmd_valid};
   assign dataReadyVec = {io_client_1_rd_data_ready, io_client_0_rd_data_ready};
   assign cmdVec[0]    = {io_client_0_rd_cmd_bits_addr,
                          io_client_0_rd_cmd_bits_len,
                          io_client_0_rd_cmd_bits_tag};
   assign cmdVec[1]    = {io_client_1_rd_cmd_bits_addr,
                          io_client_1_rd_cmd_bits_len,
                          io_client_1_rd_cmd_bits_tag};
   assign memBeat      = {io_mem_rd_data_bits_data, io_mem_rd_data_bits_tag};

   // ---------------------------------------------------------------------
   // Command arbitration
   // ---------------------------------------------------------------------
   arb_state_t arbState;
   arb_state_t arbNext;
   client_id_t rrPtr;      // client favoured when both request
   client_id_t heldId;     // grant frozen while ARB_HELD
   client_id_t grantId;
   logic       memCmdValid;
   logic       cmdHs;

   logic       fifoFull;
   logic       fifoEmpty;
   inflight_t  head;
   inflight_t  pushEntry;

   always_comb begin : arbComb
      arbNext = arbState;
      grantId = rrPtr;

      if (arbState == ARB_HELD) begin
         grantId = heldId;
      end else if (cmdValidVec == 2'b01) begin
         grantId = CLIENT_INP;
      end else if (cmdValidVec == 2'b10) begin
         grantId = CLIENT_WGT;
      end

      memCmdValid = outEn & cmdValidVec[grantId] & ~fifoFull;
      cmdHs       = memCmdValid & io_mem_rd_cmd_ready;

      // Any command shown but not taken freezes the grant; only the
      // handshake releases it.
      if (cmdHs) begin
         arbNext = ARB_OPEN;
      end else if (memCmdValid) begin
         arbNext = ARB_HELD;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         arbState <= ARB_OPEN;
         heldId   <= CLIENT_INP;
         rrPtr    <= CLIENT_INP;
      end else begin
         arbState <= arbNext;
         if (memCmdValid && !io_mem_rd_cmd_ready) begin
            heldId <= grantId;
         end
         if (cmdHs) begin
            rrPtr <= otherClient(grantId);
         end
      end
   end

   // ---------------------------------------------------------------------
   // In-flight burst tracking
   // ---------------------------------------------------------------------
   logic [LEN_W-1:0] beatCnt;
   logic             memDataReady;
   logic             dataHs;
   logic             lastBeat;
   logic             errReg;

   assign pushEntry = '{id: grantId, len: cmdVec[grantId].len};

   inflight_fifo #(
      .DEPTH     (MAX_OUTSTANDING)
   ) uFifo (
      .clock     (clock),
      .reset     (reset),
      .push      (cmdHs),
      .pushEntry (pushEntry),
      .pop       (lastBeat),
      .full      (fifoFull),
      .empty     (fifoEmpty),
      .head      (head)
   );

   // Per-client handshake outputs: command ready only for the granted
   // client on the handshake cycle, data valid only for the head owner.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : gClient
         assign cmdReadyVec[gi]  = cmdHs & (grantId == client_id_t'(gi));
         assign dataValidVec[gi] = outEn & io_mem_rd_data_valid & ~fifoEmpty
                                   & (head.id == client_id_t'(gi));
      end
   endgenerate

   always_comb begin : dataReadyComb
      memDataReady = 1'b0;
      if (outEn) begin
         if (fifoEmpty) begin
            // Nobody owns this beat: take it so memory is not wedged.
            memDataReady = io_mem_rd_data_valid;
         end else begin
            memDataReady = dataReadyVec[head.id];
         end
      end
   end

   assign dataHs   = io_mem_rd_data_valid & memDataReady & ~fifoEmpty;
   assign lastBeat = dataHs & (beatCnt == head.len);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         beatCnt <= '0;
         errReg  <= 1'b0;
      end else begin
         if (lastBeat) begin
            beatCnt <= '0;
         end else if (dataHs) begin
            beatCnt <= beatCnt + BEAT_ONE;
         end
         if (io_mem_rd_data_valid && fifoEmpty) begin
            errReg <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign io_mem_rd_cmd_valid     = memCmdValid;
   assign io_mem_rd_cmd_bits_addr = cmdVec[grantId].addr;
   assign io_mem_rd_cmd_bits_len  = cmdVec[grantId].len;
   assign io_mem_rd_cmd_bits_tag  = cmdVec[grantId].tag;

   assign io_client_0_rd_cmd_ready = cmdReadyVec[0];
   assign io_client_1_rd_cmd_ready = cmdReadyVec[1];

   assign io_client_0_rd_data_valid     = dataValidVec[0];
   assign io_client_1_rd_data_valid     = dataValidVec[1];
   assign io_client_0_rd_data_bits_data = memBeat.data;
   assign io_client_0_rd_data_bits_tag  = memBeat.tag;
   assign io_client_1_rd_data_bits_data = memBeat.data;
   assign io_client_1_rd_data_bits_tag  = memBeat.tag;

   assign io_mem_rd_data_ready = memDataReady;
   assign io_busy              = ~fifoEmpty;
   assign io_err               = errReg;

endmodule

// File: tb/tb_vme_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vme_rd_arbiter
//   Directed scenarios with literal expectations, then a randomized run.
//   A queue-based reference model of the arbiter is checked against the DUT
//   on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_vme_rd_arbiter;
   import vme_pkg::*;

   localparam int MAXO = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   // stimulus
   logic              cVal  [2];
   logic [ADDR_W-1:0] cAddr [2];
   logic [LEN_W-1:0]  cLen  [2];
   logic [TAG_W-1:0]  cTag  [2];
   logic              cDRdy [2];
   logic              memCmdReady;
   logic              memDataValid;
   logic [DATA_W-1:0] memData;
   logic [TAG_W-1:0]  memTag;

   // DUT outputs
   logic              c0Rdy, c1Rdy, c0DVal, c1DVal;
   logic [DATA_W-1:0] c0Data, c1Data;
   logic [TAG_W-1:0]  c0DTag, c1DTag;
   logic              memCmdValid, memDataReady, busy, err;
   logic [ADDR_W-1:0] memAddr;
   logic [LEN_W-1:0]  memLen;
   logic [TAG_W-1:0]  memCmdTag;

   vme_rd_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
      .clock                         (clock),
      .reset                         (reset),
      .io_client_0_rd_cmd_valid      (cVal[0]),
      .io_client_0_rd_cmd_ready      (c0Rdy),
      .io_client_0_rd_cmd_bits_addr  (cAddr[0]),
      .io_client_0_rd_cmd_bits_len   (cLen[0]),
      .io_client_0_rd_cmd_bits_tag   (cTag[0]),
      .io_client_0_rd_data_valid     (c0DVal),
      .io_client_0_rd_data_ready     (cDRdy[0]),
      .io_client_0_rd_data_bits_data (c0Data),
      .io_client_0_rd_data_bits_tag  (c0DTag),
      .io_client_1_rd_cmd_valid      (cVal[1]),
      .io_client_1_rd_cmd_ready      (c1Rdy),
      .io_client_1_rd_cmd_bits_addr  (cAddr[1]),
      .io_client_1_rd_cmd_bits_len   (cLen[1]),
      .io_client_1_rd_cmd_bits_tag   (cTag[1]),
      .io_client_1_rd_data_valid     (c1DVal),
      .io_client_1_rd_data_ready     (cDRdy[1]),
      .io_client_1_rd_data_bits_data (c1Data),
      .io_client_1_rd_data_bits_tag  (c1DTag),
      .io_mem_rd_cmd_valid           (memCmdValid),
      .io_mem_rd_cmd_ready           (memCmdReady),
      .io_mem_rd_cmd_bits_addr       (memAddr),
      .io_mem_rd_cmd_bits_len        (memLen),
      .io_mem_rd_cmd_bits_tag        (memCmdTag),
      .io_mem_rd_data_valid          (memDataValid),
      .io_mem_rd_data_ready          (memDataReady),
      .io_mem_rd_data_bits_data      (memData),
      .io_mem_rd_data_bits_tag       (memTag),
      .io_busy                       (busy),
      .io_err                        (err)
   );

   int nChecks = 0;
   int nFail   = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model: queue of outstanding bursts plus a few scalars.
   // ---------------------------------------------------------------------
   typedef struct { bit id; int len; } burst_t;
   burst_t q[$];
   int beat;
   bit rr, locked, lockId, errM;
   bit lastHs [2];

   bit mG, mFull, mCmdV, mCmdHs, mDHs, mDV0, mDV1, mMemDR;

   always @(negedge clock) begin : cmpProc
      if (!reset) begin
         chk("reset_outputs", {c0Rdy, c1Rdy, c0DVal, c1DVal, memCmdValid, memDataReady, busy, err}, 8'h00);
         q.delete();
         beat = 0; rr = 0; locked = 0; lockId = 0; errM = 0;
         lastHs[0] = 0; lastHs[1] = 0;
      end else begin
         // who holds the command grant this cycle
         if (locked)                mG = lockId;
         else if (cVal[0] && !cVal[1]) mG = 1'b0;
         else if (cVal[1] && !cVal[0]) mG = 1'b1;
         else                       mG = rr;
         mFull  = (q.size() == MAXO);
         mCmdV  = cVal[mG] && !mFull;
         mCmdHs = mCmdV && memCmdReady;

         chk("m_cmdValid", memCmdValid, mCmdV);
         if (mCmdV) begin
            chk("m_cmdAddr", memAddr, cAddr[mG]);
            chk("m_cmdLen", memLen, cLen[mG]);
            chk("m_cmdTag", memCmdTag, cTag[mG]);
         end
         chk("m_c0CmdReady", c0Rdy, mCmdHs && mG == 1'b0);
         chk("m_c1CmdReady", c1Rdy, mCmdHs && mG == 1'b1);

         if (q.size() == 0) begin
            mDV0 = 0; mDV1 = 0; mMemDR = memDataValid; mDHs = 0;
         end else begin
            mDV0   = memDataValid && q[0].id == 1'b0;
            mDV1   = memDataValid && q[0].id == 1'b1;
            mMemDR = cDRdy[q[0].id];
            mDHs   = memDataValid && mMemDR;
         end
         chk("m_c0DataValid", c0DVal, mDV0);
         chk("m_c1DataValid", c1DVal, mDV1);
         chk("m_memDataReady", memDataReady, mMemDR);
         chk("m_c0Data", c0Data, memData);
         chk("m_c1Data", c1Data, memData);
         chk("m_c0DTag", c0DTag, memTag);
         chk("m_c1DTag", c1DTag, memTag);
         chk("m_busy", busy, q.size() != 0);
         chk("m_err", err, errM);

         // advance to the state after the coming rising edge
         if (q.size() == 0 && memDataValid) errM = 1;
         if (mDHs) begin
            if (beat == q[0].len) begin
               void'(q.pop_front());
               beat = 0;
            end else begin
               beat++;
            end
         end
         if (mCmdHs) begin
            q.push_back('{mG, int'(cLen[mG])});
            rr = !mG;
            locked = 0;
         end else if (mCmdV) begin
            locked = 1;
            lockId = mG;
         end
         lastHs[0] = mCmdHs && mG == 1'b0;
         lastHs[1] = mCmdHs && mG == 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idleInputs();
      for (int i = 0; i < 2; i++) begin
         cVal[i] = 0; cAddr[i] = '0; cLen[i] = '0; cTag[i] = '0; cDRdy[i] = 0;
      end
      memCmdReady = 0; memDataValid = 0; memData = '0; memTag = '0;
   endtask

   task automatic doReset();
      reset = 1'b0;
      idleInputs();
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
   endtask

   bit pat [4];
   int delivered;

   initial begin
      #1;
      doReset();

      // ---- single burst: client 0, addr 0x1000, len 3 -------------------
      cVal[0] = 1; cAddr[0] = 32'h1000; cLen[0] = 8'd3; cTag[0] = 21'h00055;
      memCmdReady = 1;
      #1;
      chk("sb_cmdValid", memCmdValid, 1'b1);
      chk("sb_cmdAddr", memAddr, 32'h1000);
      chk("sb_cmdLen", memLen, 8'd3);
      chk("sb_cmdTag", memCmdTag, 21'h00055);
      chk("sb_c0Ready", c0Rdy, 1'b1);
      tick();
      cVal[0] = 0; memCmdReady = 0; cDRdy[0] = 1; cDRdy[1] = 1;
      for (int b = 0; b < 4; b++) begin
         memDataValid = 1; memData = 64'hA0 + 64'(b); memTag = 21'h00055;
         #1;
         chk("sb_c0DataValid", c0DVal, 1'b1);
         chk("sb_c1DataValid", c1DVal, 1'b0);
         chk("sb_c0Data", c0Data, 64'hA0 + 64'(b));
         chk("sb_busyDuring", busy, 1'b1);
         tick();
      end
      memDataValid = 0;
      #1;
      chk("sb_busyAfter", busy, 1'b0);
      tick();

      // ---- contention: grants 0,1,0,1 then FIFO full ---------------------
      doReset();
      cVal[0] = 1; cAddr[0] = 32'h100; cLen[0] = 8'd3; cTag[0] = 21'h1;
      cVal[1] = 1; cAddr[1] = 32'h200; cLen[1] = 8'd1; cTag[1] = 21'h2;
      memCmdReady = 1; cDRdy[0] = 1; cDRdy[1] = 1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("ct_c0Ready", c0Rdy, (k % 2) == 0);
         chk("ct_c1Ready", c1Rdy, (k % 2) == 1);
         tick();
      end
      #1;
      chk("ct_fullCmdValid", memCmdValid, 1'b0);
      chk("ct_fullReady", {c0Rdy, c1Rdy}, 2'b00);
      tick();
      memDataValid = 1;
      for (int b = 0; b < 4; b++) begin
         #1;
         chk("ct_beatToC0", {c0DVal, c1DVal}, 2'b10);
         chk("ct_fullBlocksPush", c0Rdy, 1'b0);
         tick();
      end
      memDataValid = 0;
      #1;
      chk("ct_c0ReadyAfterPop", c0Rdy, 1'b1);
      tick();

      // ---- stall lock ----------------------------------------------------
      doReset();
      cVal[0] = 1; cAddr[0] = 32'h2000; cLen[0] = 8'd0; cTag[0] = 21'h7;
      memCmdReady = 1;
      #1;
      chk("sl_firstC0Ready", c0Rdy, 1'b1);
      tick();
      memCmdReady = 0; cAddr[0] = 32'h3000; cLen[0] = 8'd2; cTag[0] = 21'h11;
      #1;
      chk("sl_cmdValid", memCmdValid, 1'b1);
      chk("sl_c0NoReady", c0Rdy, 1'b0);
      tick();
      cVal[1] = 1; cAddr[1] = 32'h4000; cLen[1] = 8'd5; cTag[1] = 21'h22;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("sl_addrHeld", memAddr, 32'h3000);
         chk("sl_lenHeld", memLen, 8'd2);
         chk("sl_tagHeld", memCmdTag, 21'h11);
         chk("sl_noReady", {c0Rdy, c1Rdy}, 2'b00);
         tick();
      end
      memCmdReady = 1;
      #1;
      chk("sl_hsReady", {c0Rdy, c1Rdy}, 2'b10);
      tick();
      cVal[0] = 0;
      #1;
      chk("sl_nextC1", c1Rdy, 1'b1);
      tick();

      // ---- back-pressure on a len=1 burst for client 1 --------------------
      doReset();
      cVal[1] = 1; cAddr[1] = 32'h5000; cLen[1] = 8'd1; cTag[1] = 21'h33;
      memCmdReady = 1;
      #1;
      chk("bp_c1Ready", c1Rdy, 1'b1);
      tick();
      cVal[1] = 0; memCmdReady = 0; memDataValid = 1;
      pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
      delivered = 0;
      for (int k = 0; k < 4; k++) begin
         cDRdy[1] = pat[k]; cDRdy[0] = !pat[k];
         memData = 64'hB00 + 64'(k);
         #1;
         chk("bp_memReadyMirror", memDataReady, pat[k]);
         chk("bp_routing", {c0DVal, c1DVal}, 2'b01);
         chk("bp_busy", busy, 1'b1);
         if (c1DVal && cDRdy[1]) delivered++;
         tick();
      end
      memDataValid = 0;
      #1;
      chk("bp_delivered", delivered, 2);
      chk("bp_busyAfter", busy, 1'b0);
      tick();

      // ---- stray beat -> sticky error ------------------------------------
      doReset();
      memDataValid = 1; memData = 64'hDEAD;
      #1;
      chk("er_memReady", memDataReady, 1'b1);
      chk("er_noClientValid", {c0DVal, c1DVal}, 2'b00);
      chk("er_errBefore", err, 1'b0);
      tick();
      memDataValid = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("er_errSticky", err, 1'b1);
         tick();
      end

      // ---- async reset mid-burst -----------------------------------------
      doReset();
      cVal[0] = 1; cAddr[0] = 32'h6000; cLen[0] = 8'd3; cTag[0] = 21'h44;
      memCmdReady = 1;
      tick();
      cVal[0] = 0; memCmdReady = 0; cDRdy[0] = 1; memDataValid = 1;
      tick();
      #1;
      chk("ar_beat2Valid", c0DVal, 1'b1);
      reset = 1'b0;
      cVal[0] = 1; cVal[1] = 1; memCmdReady = 1;
      #1;
      chk("ar_outputsZero", {c0Rdy, c1Rdy, c0DVal, c1DVal, memCmdValid, memDataReady, busy, err}, 8'h00);
      memDataValid = 0;
      @(posedge clock);
      #1 reset = 1'b1;
      #1;
      chk("ar_busyCleared", busy, 1'b0);
      chk("ar_errCleared", err, 1'b0);
      chk("ar_firstGrantC0", {c0Rdy, c1Rdy}, 2'b10);
      tick();

      // ---- randomized traffic --------------------------------------------
      doReset();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (cyc == 2000) doReset();
         for (int i = 0; i < 2; i++) begin
            if (!cVal[i] || lastHs[i]) begin
               cVal[i]  = ($urandom_range(0, 99) < 50);
               cAddr[i] = $urandom;
               cLen[i]  = LEN_W'($urandom_range(0, ($urandom_range(0, 9) == 0) ? 15 : 3));
               cTag[i]  = TAG_W'($urandom);
            end
            cDRdy[i] = ($urandom_range(0, 99) < 70);
         end
         memCmdReady  = ($urandom_range(0, 99) < 70);
         memDataValid = (q.size() != 0) && ($urandom_range(0, 99) < 70);
         memData      = {$urandom, $urandom};
         memTag       = TAG_W'($urandom);
         tick();
      end
      idleInputs();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
